// File: rtl/iir_df1_biquad_axis.sv
// Direct Form 1 biquad, Q2.14 coefficients, one result per accepted sample, 3-clock latency.
// Build option: define IIR_BIQUAD_ROUND_EN for round-half-up instead of floor before the >>>14.
module iir_df1_biquad_axis #(
  parameter logic signed [15:0] a1_int_coeff = -16'sd31880,
  parameter logic signed [15:0] a2_int_coeff =  16'sd15531,
  parameter logic signed [15:0] bo_int_coeff =  16'sd167,
  parameter logic signed [15:0] b1_int_coeff = -16'sd302,
  parameter logic signed [15:0] b2_int_coeff =  16'sd167
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  input  logic [15:0] s_axis_tdata,
  output logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid
);

  localparam int STAGES = 3;
  localparam int FRAC   = 14;

`ifdef IIR_BIQUAD_ROUND_EN
  localparam logic signed [34:0] RND_BIAS = 35'sd8192;
`else
  localparam logic signed [34:0] RND_BIAS = 35'sd0;
`endif

  // vld_pipe[0]: sample captured, [1]: products, [2]: accumulator, [3]: output pulse
  logic [STAGES:0]     vld_pipe;
  logic signed [15:0]  x_n, x1, x2, y1, y2;
  logic signed [31:0]  prod [5];
  logic signed [34:0]  acc;
  logic signed [34:0]  acc_sh;
  logic signed [15:0]  y_sat;
  logic                accept;

  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  assign accept        = s_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = vld_pipe[STAGES];

  always_comb begin
    acc_sh = acc >>> FRAC;
    if (acc_sh > 35'sd32767)
      y_sat = 16'sh7fff;
    else if (acc_sh < -35'sd32768)
      y_sat = 16'sh8000;
    else
      y_sat = acc_sh[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe      <= '0;
      m_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      x_n           <= '0;
      x1            <= '0;
      x2            <= '0;
      y1            <= '0;
      y2            <= '0;
      acc           <= '0;
      for (int i = 0; i < 5; i++) prod[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};

      // ready drops on accept and returns on the edge that publishes the result
      if (accept)
        m_axis_tready <= 1'b0;
      else if (vld_pipe[1:0] == '0)
        m_axis_tready <= 1'b1;

      if (accept)
        x_n <= $signed(s_axis_tdata);

      if (vld_pipe[0]) begin
        prod[0] <= mul16(bo_int_coeff, x_n);
        prod[1] <= mul16(b1_int_coeff, x1);
        prod[2] <= mul16(b2_int_coeff, x2);
        prod[3] <= mul16(a1_int_coeff, y1);
        prod[4] <= mul16(a2_int_coeff, y2);
      end

      if (vld_pipe[1])
        acc <= 35'(prod[0]) + 35'(prod[1]) + 35'(prod[2])
             - 35'(prod[3]) - 35'(prod[4]) + RND_BIAS;

      // history stays frozen until here, so stage 1 always sees x[n-1], y[n-1]
      if (vld_pipe[2]) begin
        m_axis_tdata <= y_sat;
        x2           <= x1;
        x1           <= x_n;
        y2           <= y1;
        y1           <= y_sat;
      end
    end
  end

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// Directed bench for iir_df1_biquad_axis: impulse, handshake, throughput, DC, saturation, reset.
module tb_iir_df1_biquad_axis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        m_axis_tready, m_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic        sat_s_tvalid = 1'b0;
  logic [15:0] sat_s_tdata = '0;
  logic        sat_tready, sat_tvalid;
  logic [15:0] sat_tdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iir_df1_biquad_axis u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid)
  );

  // pure b0 = 32767 section for saturation corners
  iir_df1_biquad_axis #(
    .a1_int_coeff(16'sd0),
    .a2_int_coeff(16'sd0),
    .bo_int_coeff(16'sd32767),
    .b1_int_coeff(16'sd0),
    .b2_int_coeff(16'sd0)
  ) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(sat_s_tvalid),
    .s_axis_tdata (sat_s_tdata),
    .m_axis_tready(sat_tready),
    .m_axis_tdata (sat_tdata),
    .m_axis_tvalid(sat_tvalid)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at a negedge one clock after the result
  task automatic send(input bit sel, input logic signed [15:0] xv,
                      output logic signed [15:0] yv);
    int n;
    n = 0;
    while (!(sel ? sat_tready : m_axis_tready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sel) begin sat_s_tvalid = 1'b1; sat_s_tdata = xv; end
    else     begin s_axis_tvalid = 1'b1; s_axis_tdata = xv; end
    @(negedge clk);
    sat_s_tvalid  = 1'b0;
    s_axis_tvalid = 1'b0;
    n = 0;
    while (!(sel ? sat_tvalid : m_axis_tvalid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sel ? sat_tvalid : m_axis_tvalid) yv = sel ? sat_tdata : m_axis_tdata;
    else                                  yv = 'x;
    @(negedge clk);
  endtask

  task automatic send_chk(input string tag, input bit sel,
                          input logic signed [15:0] xv, input int exp);
    logic signed [15:0] yv;
    send(sel, xv, yv);
    chk(tag, yv, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_n, out_n, pulses, miss, unstable, lo, hi;
    bit a;
    logic signed [15:0] yv, ylast;

    repeat (3) @(negedge clk);
    chk("rst_tdata", $signed(m_axis_tdata), 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", m_axis_tready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", m_axis_tready, 1);

    // impulse: acc[1] = -302*16384 + 31880*167 = 375992
    send_chk("imp0", 0, 16'sd16384, 167);
`ifdef IIR_BIQUAD_ROUND_EN
    send_chk("imp1", 0, 16'sd0, 23);
    send_chk("imp2", 0, 16'sd0, 53);
`else
    send_chk("imp1", 0, 16'sd0, 22);
    send_chk("imp2", 0, 16'sd0, 51);
`endif

    // handshake: tvalid stays high through the busy window and must be ignored
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd100;
    @(negedge clk);
    s_axis_tdata = 16'd7777;
    chk("hs_rdy_e0", m_axis_tready, 0);
    chk("hs_vld_e0", m_axis_tvalid, 0);
    @(negedge clk);
    chk("hs_rdy_e1", m_axis_tready, 0);
    chk("hs_vld_e1", m_axis_tvalid, 0);
    @(negedge clk);
    chk("hs_rdy_e2", m_axis_tready, 0);
    chk("hs_vld_e2", m_axis_tvalid, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("hs_vld_e3", m_axis_tvalid, 1);
    chk("hs_rdy_e3", m_axis_tready, 1);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_axis_tvalid) pulses++;
    end
    chk("hs_no_extra", pulses, 0);

    // tvalid held for 40 clocks: accepts at edges 1,5,..,37, results at 4,..,40
    acc_n = 0;
    out_n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd1;
    for (int i = 0; i < 40; i++) begin
      a = m_axis_tready;
      if (a) acc_n++;
      @(negedge clk);
      if (m_axis_tvalid) out_n++;
      if (a) s_axis_tdata = s_axis_tdata + 16'd1;
    end
    s_axis_tvalid = 1'b0;
    chk("burst_accepts", acc_n, 10);
    chk("burst_outputs", out_n, 10);

    // DC step: floor/round leaves a deadband of rest points around 914,
    // y is at rest when 0 <= 32000 + bias - 35*y < 16384
    do_reset();
    miss = 0;
    unstable = 0;
    ylast = '0;
    for (int i = 0; i < 1000; i++) begin
      send(0, 16'sd1000, yv);
      if ($isunknown(yv)) miss++;
      if (i >= 900 && yv !== ylast) unstable++;
      ylast = yv;
    end
`ifdef IIR_BIQUAD_ROUND_EN
    lo = 681; hi = 1148;
`else
    lo = 447; hi = 914;
`endif
    chk("dc_missing", miss, 0);
    chk("dc_unsettled", unstable, 0);
    chk("dc_in_band", (ylast >= lo && ylast <= hi) ? 1 : 0, 1);

    // reset during E1 of an accepted sample; history is non-zero from the DC run
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd5000;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_axis_tvalid) pulses++;
    end
    chk("rstmid_no_pulse", pulses, 0);
    chk("rstmid_ready", m_axis_tready, 1);
    send_chk("rstmid_imp0", 0, 16'sd16384, 167);
`ifdef IIR_BIQUAD_ROUND_EN
    send_chk("rstmid_imp1", 0, 16'sd0, 23);
`else
    send_chk("rstmid_imp1", 0, 16'sd0, 22);
`endif

    // saturation: 32767*32767>>14 = 65532, -32768*32767>>14 = -65534
    send_chk("sat_pos", 1, 16'sd32767, 32767);
    send_chk("sat_neg", 1, -16'sd32768, -32768);
    send_chk("sat_edge", 1, 16'sd16384, 32767);
`ifdef IIR_BIQUAD_ROUND_EN
    send_chk("sat_lsb", 1, 16'sd1, 2);
`else
    send_chk("sat_lsb", 1, 16'sd1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
